// File: rtl/div_seq_pkg.sv
// div_seq_pkg
//   Shared definitions for the E-stage divide sequencer:
//   - divState_t : 2-bit sequencer state encoding
//   - EXE_DIV_OP / EXE_DIVU_OP : ALU op codes the E stage decodes into
//     start / signed_div
//   - isDivOp() : helper for the E stage to derive start
package div_seq_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE  = 2'b00,
        DIV_DZERO = 2'b01,
        DIV_ON    = 2'b10,
        DIV_END   = 2'b11
    } divState_t;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    function automatic logic isDivOp(input logic [7:0] aluOp);
        return (aluOp == EXE_DIV_OP) || (aluOp == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/div_seq_if.sv
// div_seq_if
//   Request/response bundle between the E stage (master) and the divide
//   sequencer (slave).
//   master drives : start, signed_div, annul, opdata1, opdata2
//   slave drives  : result {HI, LO}, div_ready, busy
interface div_seq_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 signed_div;
    logic                 annul;
    logic [WIDTH-1:0]     opdata1;
    logic [WIDTH-1:0]     opdata2;
    logic [2*WIDTH-1:0]   result;
    logic                 div_ready;
    logic                 busy;

    modport master (
        output start, signed_div, annul, opdata1, opdata2,
        input  result, div_ready, busy
    );

    modport slave (
        input  start, signed_div, annul, opdata1, opdata2,
        output result, div_ready, busy
    );
endinterface

// File: rtl/div_seq_step.sv
// div_seq_step
//   One radix-2 restoring iteration: shift the partial remainder/quotient
//   register left by one, trial-subtract the divisor from the upper
//   WIDTH+1 bits, keep the difference on no-borrow and shift in the
//   quotient bit.
//   dividendIn  : {partial remainder (WIDTH+1), quotient/dividend (WIDTH)}
//   divisor     : divisor magnitude
//   dividendOut : register value after this iteration
module div_seq_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0] dividendIn,
    input  logic [WIDTH-1:0] divisor,
    output logic [2*WIDTH:0] dividendOut
);
    logic [2*WIDTH:0] shifted;
    logic [WIDTH:0]   upper;
    logic [WIDTH+1:0] diff;
    logic             borrow;

    always_comb begin
        shifted = dividendIn << 1;
        upper   = shifted[2*WIDTH:WIDTH];
        diff    = {1'b0, upper} - {2'b00, divisor};
        borrow  = diff[WIDTH+1];
        // shifted[0] is always 0, so OR-ing places the new quotient bit.
        dividendOut = {(borrow ? upper : diff[WIDTH:0]),
                       shifted[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, ~borrow}};
    end
endmodule

// File: rtl/div_seq.sv
// div_seq
//   Multi-cycle DIV/DIVU sequencer for the E stage. Restoring division,
//   one quotient bit per cycle; div_ready pulses for one cycle when the
//   registered {HI, LO} result is valid. annul abandons the operation
//   and holds the previous result.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : div_seq_if slave (start, signed_div, annul, opdata1, opdata2 in;
//         result, div_ready, busy out)
//
//   state     | meaning
//   DIV_IDLE  | waiting for start; latches operands on acceptance
//   DIV_DZERO | divisor was zero; result forced to 0
//   DIV_ON    | iterating, one quotient bit per cycle
//   DIV_END   | result valid, div_ready high for this cycle
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    div_seq_if.slave    bus
);
    localparam int CW = $clog2(WIDTH);

    divState_t          state, stateNext;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH:0]   dividend, dividendStep;
    logic [WIDTH-1:0]   divisor;
    logic               negQuot, negRem;
    logic [2*WIDTH-1:0] resultReg, resultNext;
    logic               readyReg, busyReg;

    logic               accept, loadOps, doStep, toEnd;
    logic [WIDTH-1:0]   absA, absB, quotFixed, remFixed;

    div_seq_step #(.WIDTH(WIDTH)) uStep (
        .dividendIn  (dividend),
        .divisor     (divisor),
        .dividendOut (dividendStep)
    );

    assign accept = bus.start & ~bus.annul;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= DIV_IDLE;
        else     state <= stateNext;
    end

    // next state
    always_comb begin
        stateNext = state;
        case (state)
            DIV_IDLE: begin
                if (accept)
                    stateNext = (bus.opdata2 == '0) ? DIV_DZERO : DIV_ON;
            end
            DIV_DZERO: stateNext = DIV_END;
            DIV_ON: begin
                if (cnt == CW'(WIDTH - 1)) stateNext = DIV_END;
            end
            DIV_END:   stateNext = DIV_IDLE;
            default:   stateNext = DIV_IDLE;
        endcase
        if (bus.annul) stateNext = DIV_IDLE;
    end

    // output / datapath control
    always_comb begin
        absA = (bus.signed_div & bus.opdata1[WIDTH-1]) ? -bus.opdata1 : bus.opdata1;
        absB = (bus.signed_div & bus.opdata2[WIDTH-1]) ? -bus.opdata2 : bus.opdata2;
        // Sign fix applies to the final iteration's output, registered on entry to END.
        quotFixed = negQuot ? -dividendStep[WIDTH-1:0] : dividendStep[WIDTH-1:0];
        remFixed  = negRem  ? -dividendStep[2*WIDTH-1:WIDTH] : dividendStep[2*WIDTH-1:WIDTH];
        loadOps   = (state == DIV_IDLE) & accept;
        doStep    = (state == DIV_ON) & ~bus.annul;
        toEnd     = (stateNext == DIV_END);
        resultNext = (state == DIV_ON) ? {remFixed, quotFixed} : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            dividend  <= '0;
            divisor   <= '0;
            negQuot   <= 1'b0;
            negRem    <= 1'b0;
            resultReg <= '0;
            readyReg  <= 1'b0;
            busyReg   <= 1'b0;
        end else begin
            if (loadOps) begin
                dividend <= {{(WIDTH+1){1'b0}}, absA};
                divisor  <= absB;
                negQuot  <= bus.signed_div & (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
                negRem   <= bus.signed_div & bus.opdata1[WIDTH-1];
                cnt      <= '0;
            end
            if (doStep) begin
                dividend <= dividendStep;
                cnt      <= cnt + CW'(1);
            end
            if (toEnd) resultReg <= resultNext;
            readyReg <= toEnd;
            busyReg  <= (stateNext != DIV_IDLE);
        end
    end

    assign bus.result    = resultReg;
    assign bus.div_ready = readyReg;
    assign bus.busy      = busyReg;
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq
//   Directed vector table plus hand-written multi-cycle sequences
//   (annul, reset mid-operation, back-to-back, operand change) and a
//   short random sweep against a / and % reference.
module tb_div_seq;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    div_seq_if #(.WIDTH(32)) bus ();

    div_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] expRes;
        int          expLat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Presents an operation (start held like a stalled E stage) and waits
    // for div_ready. lat = number of clock edges from the accepting edge.
    task automatic runOp(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [63:0] res);
        lat = -1;
        res = '0;
        bus.start      = 1'b1;
        bus.signed_div = sgn;
        bus.opdata1    = a;
        bus.opdata2    = b;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (bus.div_ready) begin
                lat = n;
                res = bus.result;
                break;
            end
        end
        bus.start = 1'b0;
    endtask

    int          lat, lat2;
    logic [63:0] res, res2;
    logic [31:0] ra, rb, eq, er;
    logic        rs;
    logic        sawReady;

    initial begin
        vecs[0]  = '{1'b0, 32'd100,        32'd7,          {32'h00000002, 32'h0000000E}, 33};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD}, 33};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   {32'h00000001, 32'hFFFFFFFD}, 33};
        vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'h00000000, 32'h80000000}, 33};
        vecs[4]  = '{1'b0, 32'd5,          32'd0,          64'h0,                        2};
        vecs[5]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          {32'h00000000, 32'hFFFFFFFF}, 33};
        vecs[6]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   {32'h00000000, 32'h00000001}, 33};
        vecs[7]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   {32'hFFFFFFFE, 32'h0000000E}, 33};
        vecs[8]  = '{1'b1, 32'd0,          32'd5,          64'h0,                        33};
        vecs[9]  = '{1'b1, 32'd5,          32'd0,          64'h0,                        2};
        vecs[10] = '{1'b0, 32'hFFFFFFFF,   32'd2,          {32'h00000001, 32'h7FFFFFFF}, 33};

        rst = 1'b1;
        bus.start = 1'b0; bus.signed_div = 1'b0; bus.annul = 1'b0;
        bus.opdata1 = '0; bus.opdata2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", bus.result, 64'h0);
        check("rst_ready", {63'h0, bus.div_ready}, 64'h0);
        check("rst_busy", {63'h0, bus.busy}, 64'h0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            runOp(vecs[i].sgn, vecs[i].a, vecs[i].b, lat, res);
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].expLat));
            check($sformatf("vec%0d_res", i), res, vecs[i].expRes);
            @(posedge clk); #1;
            check($sformatf("vec%0d_readylow", i), {63'h0, bus.div_ready}, 64'h0);
        end

        // Annul at cycle 10: back to IDLE next cycle, result held, no ready.
        bus.start = 1'b1; bus.signed_div = 1'b0;
        bus.opdata1 = 32'd1000; bus.opdata2 = 32'd9;
        repeat (10) @(posedge clk);
        #1;
        check("annul_busy_before", {63'h0, bus.busy}, 64'h1);
        bus.annul = 1'b1; bus.start = 1'b0;
        @(posedge clk); #1;
        bus.annul = 1'b0;
        check("annul_busy_after", {63'h0, bus.busy}, 64'h0);
        check("annul_ready", {63'h0, bus.div_ready}, 64'h0);
        check("annul_result_held", bus.result, {32'h00000001, 32'h7FFFFFFF});
        sawReady = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus.div_ready) sawReady = 1'b1;
        end
        check("annul_no_late_ready", {63'h0, sawReady}, 64'h0);
        runOp(1'b0, 32'd9, 32'd3, lat, res);
        check("restart_lat", 64'(lat), 64'd33);
        check("restart_res", res, {32'h0, 32'h3});
        @(posedge clk); #1;

        // Reset at cycle 10 of an operation clears everything.
        bus.start = 1'b1; bus.opdata1 = 32'd1000; bus.opdata2 = 32'd10;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1; bus.start = 1'b0;
        @(posedge clk); #1;
        check("midrst_result", bus.result, 64'h0);
        check("midrst_ready", {63'h0, bus.div_ready}, 64'h0);
        check("midrst_busy", {63'h0, bus.busy}, 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Back-to-back: start stays high across the ready cycle.
        runOp(1'b0, 32'd10, 32'd3, lat, res);
        check("b2b_first_lat", 64'(lat), 64'd33);
        check("b2b_first_res", res, {32'h1, 32'h3});
        bus.start = 1'b1; bus.opdata1 = 32'd20; bus.opdata2 = 32'd6;
        lat2 = -1; res2 = '0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (bus.div_ready) begin lat2 = n; res2 = bus.result; break; end
        end
        bus.start = 1'b0;
        check("b2b_gap", 64'(lat2), 64'd34);
        check("b2b_second_res", res2, {32'h2, 32'h3});
        @(posedge clk); #1;

        // Operands change and start drops after acceptance: ignored.
        bus.start = 1'b1; bus.signed_div = 1'b0;
        bus.opdata1 = 32'd100; bus.opdata2 = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.opdata1 = 32'hDEADBEEF; bus.opdata2 = 32'd0; bus.signed_div = 1'b1;
        lat = -1; res = '0;
        for (int n = 2; n <= 40; n++) begin
            @(posedge clk); #1;
            if (bus.div_ready) begin lat = n; res = bus.result; break; end
        end
        check("opchg_lat", 64'(lat), 64'd33);
        check("opchg_res", res, {32'h2, 32'hE});
        @(posedge clk); #1;

        // Short random sweep against the language's truncating / and %.
        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if (rb == 32'h0) rb = 32'd1;
            if (rs && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd2;
            if (rs) begin
                eq = $signed(ra) / $signed(rb);
                er = $signed(ra) % $signed(rb);
            end else begin
                eq = ra / rb;
                er = ra % rb;
            end
            runOp(rs, ra, rb, lat, res);
            check($sformatf("rnd%0d_lat", i), 64'(lat), 64'd33);
            check($sformatf("rnd%0d_res", i), res, {er, eq});
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
